// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
//   - if_state_e       : fetch FSM state encoding (IDLE, REQ, VALID)
//   - DEFAULT_RESET_PC : default PC loaded on reset (word-aligned)
//   - branch_offset()  : sign-extended, word-scaled branch displacement
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_VALID = 2'd2
    } if_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch immediate counts words; scale to bytes and sign-extend to 32 bits.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// fetch_unit_npc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4  in  32  PC of the current instruction + 4
//   instr_idx in  26  instr[25:0] (jump index; [15:0] is the branch immediate)
//   rs_data   in  32  register rs value, target for jr
//   jump, jr, beq, bne, zero  in  1  decoder controls and ALU zero flag
//   next_pc   out 32  selected next PC (jr > jump > taken branch > pc_plus4)
//   misalign  out 1   jr selected with a target whose low two bits are non-zero
module fetch_unit_npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_idx,
    input  logic [31:0] rs_data,
    input  logic        jump,
    input  logic        jr,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic taken_s;

    // Priority select of the next PC; jr target is forced word-aligned.
    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        taken_s  = (beq & zero) | (bne & ~zero);
        if (jr) begin
            next_pc  = {rs_data[31:2], 2'b00};
            misalign = (rs_data[1:0] != 2'b00);
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
        end else if (taken_s) begin
            next_pc = pc_plus4 + branch_offset(instr_idx[15:0]);
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, fetches words from
// instruction memory over a req/ack handshake, presents them to decode and
// advances the PC on each retire.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   imem_req/addr (out)      fetch request and byte address (= pc_o)
//   imem_ack/rdata (in)      memory response, accepted only while requesting
//   instr_o/op_o/funct_o     captured instruction and decoder fields
//   instr_valid (out)        instruction valid for execute
//   instr_ready (in)         retire of the current instruction
//   jump/jr/beq/bne/zero/rs_data (in)  next-PC controls, sampled at retire
//   pc_o/pc_plus4_o          PC of instr_o and PC + 4
//   align_err (out)          sticky misaligned-jr flag, cleared by reset only
//   retire_cnt (out)         wrapping count of retired instructions
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [5:0]  op_o,
    output logic [5:0]  funct_o,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        jr,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        align_err,
    output logic [31:0] retire_cnt
);

    if_state_e   state_r, state_next_s;
    logic [31:0] pc_r, pc_next_s;
    logic [31:0] instr_r, instr_next_s;
    logic [31:0] cnt_r, cnt_next_s;
    logic        align_r, align_next_s;
    logic        req_r, valid_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] npc_s;
    logic        misalign_s;

    assign pc_plus4_s = pc_r + 32'd4;

    fetch_unit_npc u_npc (
        .pc_plus4  (pc_plus4_s),
        .instr_idx (instr_r[25:0]),
        .rs_data   (rs_data),
        .jump      (jump),
        .jr        (jr),
        .beq       (beq),
        .bne       (bne),
        .zero      (zero),
        .next_pc   (npc_s),
        .misalign  (misalign_s)
    );

    // Next-state and next-register values; handshakes outside their state are ignored.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        cnt_next_s   = cnt_r;
        align_next_s = align_r;
        case (state_r)
            IF_IDLE: begin
                state_next_s = IF_REQ;
            end
            IF_REQ: begin
                if (imem_ack) begin
                    state_next_s = IF_VALID;
                    instr_next_s = imem_rdata;
                end else begin
                    state_next_s = IF_REQ;
                end
            end
            IF_VALID: begin
                if (instr_ready) begin
                    state_next_s = IF_REQ;
                    pc_next_s    = npc_s;
                    cnt_next_s   = cnt_r + 32'd1;
                    align_next_s = align_r | misalign_s;
                end else begin
                    state_next_s = IF_VALID;
                end
            end
            default: begin
                state_next_s = IF_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IF_IDLE;
            pc_r    <= RESET_PC;
            instr_r <= 32'd0;
            cnt_r   <= 32'd0;
            align_r <= 1'b0;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            instr_r <= instr_next_s;
            cnt_r   <= cnt_next_s;
            align_r <= align_next_s;
            req_r   <= (state_next_s == IF_REQ);
            valid_r <= (state_next_s == IF_VALID);
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc_o        = pc_r;
    assign pc_plus4_o  = pc_plus4_s;
    assign instr_o     = instr_r;
    assign op_o        = instr_r[31:26];
    assign funct_o     = instr_r[5:0];
    assign instr_valid = valid_r;
    assign align_err   = align_r;
    assign retire_cnt  = cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_o;
    logic [5:0]  op_o;
    logic [5:0]  funct_o;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump = 1'b0, jr = 1'b0, beq = 1'b0, bne = 1'b0, zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        align_err;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_o(instr_o), .op_o(op_o), .funct_o(funct_o),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump(jump), .jr(jr), .beq(beq), .bne(bne), .zero(zero),
        .rs_data(rs_data), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .align_err(align_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        jump, jr, beq, bne, zero;
        logic [31:0] rs;
        logic [31:0] pc;
        logic [31:0] next;
        logic        align;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_ctrl();
        jump = 1'b0; jr = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
        rs_data = 32'd0; instr_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, " addr"}, imem_addr, 32'h0);
        chk({tag, " pc"}, pc_o, 32'h0);
        chk({tag, " pc4"}, pc_plus4_o, 32'h4);
        chk({tag, " instr"}, instr_o, 32'h0);
        chk({tag, " op"}, {26'd0, op_o}, 32'd0);
        chk({tag, " funct"}, {26'd0, funct_o}, 32'd0);
        chk({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, " align"}, {31'd0, align_err}, 32'd0);
        chk({tag, " cnt"}, retire_cnt, 32'd0);
    endtask

    // Reset held two cycles, released at a falling edge; returns in cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        clear_ctrl();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h000, 32'h004,  1'b0};
        vecs[1]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h004, 32'h010,  1'b0};
        vecs[2]  = '{32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h010, 32'h00C,  1'b0};
        vecs[3]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h00C, 32'h010,  1'b0};
        vecs[4]  = '{32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h010, 32'h014,  1'b0};
        vecs[5]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h014, 32'h010,  1'b0};
        vecs[6]  = '{32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h010, 32'h00C,  1'b0};
        vecs[7]  = '{32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h00C, 32'h040,  1'b0};
        vecs[8]  = '{32'h0800_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h040, 32'h400,  1'b0};
        vecs[9]  = '{32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h400, 32'h040,  1'b0};
        vecs[10] = '{32'h0800_0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h203, 32'h040, 32'h200,  1'b1};
        vecs[11] = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h200, 32'h204,  1'b1};
        vecs[12] = '{32'h1400_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h204, 32'h208,  1'b1};
        vecs[13] = '{32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h208, 32'h218,  1'b1};
        vecs[14] = '{32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h218, 32'h1000, 1'b1};

        // Zero-wait memory, ready held high: fetches at cycles 1, 3, 5.
        do_reset();
        imem_ack = 1'b1;
        imem_rdata = 32'h2008_0005;
        instr_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                chk($sformatf("zw req c%0d", c), {31'd0, imem_req}, 32'd1);
                chk($sformatf("zw addr c%0d", c), imem_addr, 32'((c - 1) * 2));
                chk($sformatf("zw valid c%0d", c), {31'd0, instr_valid}, 32'd0);
            end else begin
                chk($sformatf("zw req c%0d", c), {31'd0, imem_req}, 32'd0);
                chk($sformatf("zw valid c%0d", c), {31'd0, instr_valid}, 32'd1);
                chk($sformatf("zw op c%0d", c), {26'd0, op_o}, 32'h08);
                chk($sformatf("zw funct c%0d", c), {26'd0, funct_o}, 32'h05);
            end
            chk($sformatf("zw cnt c%0d", c), retire_cnt, 32'((c - 1) / 2));
        end

        // Three wait states, then a long stall in VALID with noise on inputs.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("ws req c%0d", c), {31'd0, imem_req}, 32'd1);
            chk($sformatf("ws addr c%0d", c), imem_addr, 32'h0);
            chk($sformatf("ws valid c%0d", c), {31'd0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("ws valid after ack", {31'd0, instr_valid}, 32'd1);
        chk("ws req after ack", {31'd0, imem_req}, 32'd0);
        imem_rdata = 32'hCAFE_F00D;
        jr = 1'b1;
        jump = 1'b1;
        rs_data = 32'h0000_0003;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("stall req %0d", c), {31'd0, imem_req}, 32'd0);
            chk($sformatf("stall valid %0d", c), {31'd0, instr_valid}, 32'd1);
            chk($sformatf("stall pc %0d", c), pc_o, 32'h0);
            chk($sformatf("stall instr %0d", c), instr_o, 32'h1234_5678);
            chk($sformatf("stall cnt %0d", c), retire_cnt, 32'd0);
            chk($sformatf("stall align %0d", c), {31'd0, align_err}, 32'd0);
        end
        imem_ack = 1'b0;
        clear_ctrl();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("stall release req", {31'd0, imem_req}, 32'd1);
        chk("stall release addr", imem_addr, 32'h4);
        chk("stall release cnt", retire_cnt, 32'd1);

        // Next-PC vector chain from a fresh reset; each vector starts in REQ.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("v%0d req", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("v%0d addr", i), imem_addr, vecs[i].pc);
            imem_ack = 1'b1;
            imem_rdata = vecs[i].instr;
            @(negedge clk);
            imem_ack = 1'b0;
            chk($sformatf("v%0d valid", i), {31'd0, instr_valid}, 32'd1);
            chk($sformatf("v%0d instr", i), instr_o, vecs[i].instr);
            chk($sformatf("v%0d pc4", i), pc_plus4_o, vecs[i].pc + 32'd4);
            jump = vecs[i].jump;
            jr = vecs[i].jr;
            beq = vecs[i].beq;
            bne = vecs[i].bne;
            zero = vecs[i].zero;
            rs_data = vecs[i].rs;
            instr_ready = 1'b1;
            @(negedge clk);
            clear_ctrl();
            chk($sformatf("v%0d next", i), imem_addr, vecs[i].next);
            chk($sformatf("v%0d align", i), {31'd0, align_err}, {31'd0, vecs[i].align});
            chk($sformatf("v%0d cnt", i), retire_cnt, 32'(i + 1));
        end

        // Reset pulse during REQ with a late ack that must not be captured.
        chk("rst pre req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async req", {31'd0, imem_req}, 32'd0);
        chk("rst async addr", imem_addr, 32'h0);
        chk("rst async cnt", retire_cnt, 32'd0);
        chk("rst async align", {31'd0, align_err}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst idle ack req", {31'd0, imem_req}, 32'd1);
        chk("rst idle ack valid", {31'd0, instr_valid}, 32'd0);
        chk("rst idle ack instr", instr_o, 32'h0);
        chk("rst restart addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rst refetch valid", {31'd0, instr_valid}, 32'd1);
        chk("rst refetch instr", instr_o, 32'hDEAD_BEEF);
        chk("rst refetch cnt", retire_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
